// File: rtl/mux_pkg.sv
// mux_pkg
// Shared types and limits for the mux_rr streaming multiplexer.
//   mode_e   : channel choice policy (direct select / round-robin)
//   ostate_e : output stage occupancy (SKID only reachable when MUX_SKID_EN is defined)
//   MUX_NCH_MAX : largest supported channel count
package mux_pkg;

  localparam int MUX_NCH_MAX = 64;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } ostate_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin grant: first asserted request at or after ptr,
// wrapping to the lowest asserted request when nothing at/after ptr is set.
// Ports:
//   req     in  NCH   request vector
//   ptr     in  SELW  highest-priority index for this cycle
//   gnt     out NCH   one-hot grant (all zero when no request)
//   gnt_idx out SELW  index of the granted request
//   gnt_any out 1     at least one request present
module rr_arbiter #(
  parameter int NCH  = 32,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [NCH-1:0]  hi_req;
  logic [SELW-1:0] hi_idx;
  logic [SELW-1:0] lo_idx;

  // Two parallel lowest-set-bit searches instead of a rotating chain: one over
  // requests at/after ptr, one over all requests. The masked search wins when it
  // finds anything, which gives the wrap-around order with a short logic depth.
  always_comb begin
    hi_req = '0;
    for (int i = 0; i < NCH; i++) begin
      hi_req[i] = req[i] && (i >= int'(ptr));
    end
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hi_req[i]) hi_idx = SELW'(i);
      if (req[i])    lo_idx = SELW'(i);
    end
    gnt_any = |req;
    gnt_idx = (|hi_req) ? hi_idx : lo_idx;
    gnt     = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_rr.sv
// mux_rr
// N-channel registered multiplexer with valid/ready handshake on every channel.
// mode=0 picks channel sel directly; mode=1 grants valid channels round-robin.
// Build option: define MUX_SKID_EN to add a one-word skid register so that
// in_ready no longer depends combinationally on out_ready.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mode              0 direct select, 1 round-robin
//   sel   [SELW]      channel used in direct mode (>= NCH means no grant)
//   in_valid [NCH]    per-channel request
//   in_data [NCH*W]   channel k at [k*WIDTH +: WIDTH]
//   in_ready [NCH]    per-channel accept, at most one bit high
//   out_valid/out_data/out_ch  registered output word and its source channel
//   out_ready         consumer accept
module mux_rr
  import mux_pkg::*;
#(
  parameter int NCH   = 32,
  parameter int WIDTH = 32,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  ostate_e         state;
  logic [SELW-1:0] ptr;
  mode_e           cur_mode;

  logic [NCH-1:0]   rr_gnt;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;

  logic [NCH-1:0]   onehot;
  logic [SELW-1:0]  g;
  logic             g_any;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] g_data;

`ifdef MUX_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic [SELW-1:0]  skid_ch;
`endif

  assign cur_mode = mode_e'(mode);

  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Grant, handshake and data selection. The data mux is AND-OR over the
  // one-hot grant so an out-of-range sel never indexes past in_data.
  always_comb begin
`ifdef MUX_SKID_EN
    accept = (state != SKID);
`else
    accept = (state == EMPTY) || out_ready;
`endif
    onehot = '0;
    if (cur_mode == MODE_RR) begin
      g      = rr_idx;
      g_any  = rr_any;
      onehot = rr_gnt;
    end else begin
      g     = sel;
      g_any = (int'(sel) < NCH);
      if (g_any) onehot[sel] = 1'b1;
    end
    in_ready = (rst_n && g_any && accept) ? onehot : '0;
    xfer     = rst_n && g_any && accept && (|(onehot & in_valid));
    g_data   = '0;
    for (int k = 0; k < NCH; k++) begin
      g_data = g_data | (in_data[k*WIDTH +: WIDTH] & {WIDTH{onehot[k]}});
    end
  end

  // Output stage and round-robin pointer. Draining and loading in the same
  // cycle keeps the stage FULL so back-to-back words have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
`ifdef MUX_SKID_EN
      skid_data <= '0;
      skid_ch   <= '0;
`endif
    end else begin
      if (xfer && cur_mode == MODE_RR) begin
        ptr <= (g == SELW'(NCH - 1)) ? '0 : g + 1'b1;
      end
      case (state)
        EMPTY: begin
          if (xfer) begin
            out_data  <= g_data;
            out_ch    <= g;
            out_valid <= 1'b1;
            state     <= FULL;
          end
        end
        FULL: begin
          if (xfer) begin
`ifdef MUX_SKID_EN
            if (out_ready) begin
              out_data <= g_data;
              out_ch   <= g;
            end else begin
              skid_data <= g_data;
              skid_ch   <= g;
              state     <= SKID;
            end
`else
            out_data <= g_data;
            out_ch   <= g;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
`ifdef MUX_SKID_EN
        SKID: begin
          if (out_ready) begin
            out_data <= skid_data;
            out_ch   <= skid_ch;
            state    <= FULL;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr.sv
// tb_mux_rr
// Directed bench for mux_rr (NCH=32, WIDTH=32) plus a second instance with
// NCH=20, WIDTH=8 for out-of-range select. Expected words are queued when a
// transfer is predicted and popped when the consumer handshake completes.
// Honours MUX_SKID_EN for the stage capacity model.
module tb_mux_rr;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  ch;
  } item_t;

  logic           clk;
  logic           rst_n;
  logic           mode;
  logic [4:0]     sel;
  logic [31:0]    in_valid;
  logic [1023:0]  in_data;
  logic [31:0]    in_ready;
  logic           out_valid;
  logic [31:0]    out_data;
  logic [4:0]     out_ch;
  logic           out_ready;

  logic           mode_b;
  logic [4:0]     sel_b;
  logic [19:0]    in_valid_b;
  logic [159:0]   in_data_b;
  logic [19:0]    in_ready_b;
  logic           out_valid_b;
  logic [7:0]     out_data_b;
  logic [4:0]     out_ch_b;
  logic           out_ready_b;

  int    checks;
  int    errors;
  item_t sb[$];
  int    model_count;
  int    model_ptr;
  bit    prev_hold;
  logic [31:0] prev_data;
  logic [4:0]  prev_ch;

  mux_rr #(.NCH(32), .WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  mux_rr #(.NCH(20), .WIDTH(8)) dut20 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode_b),
    .sel       (sel_b),
    .in_valid  (in_valid_b),
    .in_data   (in_data_b),
    .in_ready  (in_ready_b),
    .out_valid (out_valid_b),
    .out_data  (out_data_b),
    .out_ch    (out_ch_b),
    .out_ready (out_ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference grant: walk from ptr one index at a time.
  function automatic int modelGrant(input logic m, input int s, input logic [31:0] v,
                                    input int p, input int n);
    if (!m) return (s < n) ? s : -1;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (p + i) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Drive one cycle of stimulus, check handshake/state against the model,
  // and queue the word expected to be captured at the next edge.
  task automatic applyStimulus(input logic m, input logic [4:0] s, input logic [31:0] v,
                               input logic ordy, input int fix_ch = -1,
                               input logic [31:0] fix_data = 32'h0);
    int g;
    bit acc;
    bit xf;
    bit drained;
    logic [31:0] exp_rdy;
    item_t it;
    @(negedge clk);
    mode = m;
    sel = s;
    in_valid = v;
    out_ready = ordy;
    for (int k = 0; k < 32; k++) in_data[k*32 +: 32] = $urandom();
    if (fix_ch >= 0) in_data[fix_ch*32 +: 32] = fix_data;
    #1;
    checkOutput("out_valid", 64'(out_valid), 64'(model_count > 0));
    checkOutput("ptr", 64'(dut.ptr), 64'(model_ptr));
    if (prev_hold) begin
      checkOutput("held_data", 64'(out_data), 64'(prev_data));
      checkOutput("held_ch", 64'(out_ch), 64'(prev_ch));
    end
    g = modelGrant(m, int'(s), v, model_ptr, 32);
`ifdef MUX_SKID_EN
    acc = (model_count < 2);
`else
    acc = (model_count == 0) || ordy;
`endif
    exp_rdy = (g >= 0 && acc) ? (32'd1 << g) : 32'd0;
    checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
    xf = (g >= 0) && acc && v[g];
    if (xf) begin
      it.data = in_data[g*32 +: 32];
      it.ch = 5'(g);
      sb.push_back(it);
      if (m) model_ptr = (g + 1) % 32;
    end
    drained = (model_count > 0) && ordy;
    prev_hold = (model_count > 0) && !ordy;
    prev_data = out_data;
    prev_ch = out_ch;
    model_count = model_count + int'(xf) - int'(drained);
  endtask

  // Consumer side: just before each rising edge, a completed handshake
  // must match the oldest queued word.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
        checkOutput("sb_occupancy", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          item_t it;
          it = sb.pop_front();
          checkOutput("sb_data", 64'(out_data), 64'(it.data));
          checkOutput("sb_ch", 64'(out_ch), 64'(it.ch));
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    model_count = 0;
    model_ptr = 0;
    prev_hold = 0;
    prev_data = '0;
    prev_ch = '0;
    rst_n = 1'b0;
    mode = 1'b0;
    sel = '0;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    mode_b = 1'b0;
    sel_b = '0;
    in_valid_b = '0;
    in_data_b = '0;
    out_ready_b = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    in_valid = 32'hFFFF_FFFF;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_ch", 64'(out_ch), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Direct select, including the top channel.
    applyStimulus(1'b0, 5'd5, 32'h0000_0020, 1'b1, 5, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 5'd31, 32'h8000_0000, 1'b1, 31, 32'h0000_0001);
    checkOutput("direct_sel5_data", 64'(out_data), 64'hDEAD_BEEF);
    checkOutput("direct_sel5_ch", 64'(out_ch), 64'd5);
    applyStimulus(1'b0, 5'd9, 32'h0, 1'b1);
    checkOutput("direct_sel31_data", 64'(out_data), 64'h1);
    applyStimulus(1'b0, 5'd9, 32'h0, 1'b1);

    // Round-robin over channels 3, 7 and 31.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'd0, 32'h8000_0088, 1'b1);

    // Asynchronous reset while a word is held.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_ch", 64'(out_ch), 64'd0);
    checkOutput("midrst_ptr", 64'(dut.ptr), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    model_count = 0;
    model_ptr = 0;
    prev_hold = 0;
    in_valid = '0;
    mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure then release.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd2, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd2, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(1'b0, 5'd2, 32'h0, 1'b1);
    applyStimulus(1'b0, 5'd2, 32'h0, 1'b1);

    // Simultaneous drain and fill, round-robin over all channels.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd0, 32'h0, 1'b1);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    // Out-of-range select on the 20-channel instance.
    @(negedge clk);
    mode_b = 1'b0;
    sel_b = 5'd25;
    in_valid_b = 20'hFFFFF;
    out_ready_b = 1'b1;
    #1;
    checkOutput("inv_sel_in_ready", 64'(in_ready_b), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("inv_sel_out_valid", 64'(out_valid_b), 64'd0);
      checkOutput("inv_sel_in_ready_hold", 64'(in_ready_b), 64'd0);
    end
    @(negedge clk);
    sel_b = 5'd19;
    in_data_b[19*8 +: 8] = 8'h5A;
    #1;
    checkOutput("sel19_in_ready", 64'(in_ready_b), 64'h80000);
    @(negedge clk);
    in_valid_b = '0;
    #1;
    checkOutput("sel19_out_valid", 64'(out_valid_b), 64'd1);
    checkOutput("sel19_out_data", 64'(out_data_b), 64'h5A);
    checkOutput("sel19_out_ch", 64'(out_ch_b), 64'd19);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr.md
# mux_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshake. It is the streaming successor of the 32:1 bit mux. Channel choice is either a direct select (`mode`=0) or fair round-robin among valid requesters (`mode`=1). Used in the datapath wherever several producers share one registered consumer port, such as writeback sources or debug/trace taps.

## Interface
- `NCH`, default 32: number of input channels, 2..64.
- `WIDTH`, default 32: data bits per channel.
- `SELW`, default $clog2(NCH): select/channel-index width (derived; do not override).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock domain; asynchronous assert, synchronous release upstream.
- `mode`  in  1  0 = direct select, 1 = round-robin.
- `sel`  in  SELW  channel index used when `mode`=0.
- `in_valid`  in  NCH  per-channel request.
- `in_data`  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `in_ready`  out  NCH  per-channel accept; at most one bit high per cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered word.
- `out_ch`  out  SELW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  consumer accept.

## Operation
- Output stage states: EMPTY, FULL, plus SKID when MUX_SKID_EN is defined.
- `accept` = stage can take a word this cycle (EMPTY, or FULL with `out_ready`=1).
- Grant selection, `g`:
  - `mode`=0: `g` = `sel`. If `sel` >= NCH, there is no grant and all `in_ready` are 0.
  - `mode`=1: `g` = the first index with `in_valid` high, searching `ptr`, `ptr`+1, …, wrapping at NCH. If no input is valid, there is no grant.
- `in_ready[g]` = `accept`; every other `in_ready` bit is 0. `in_ready` does not depend on `in_valid[g]` in mode 0.
- A transfer happens when `in_valid[g]` && `in_ready[g]`. On transfer, at the next edge:
  - `out_data` ← `in_data[g]`, `out_ch` ← `g`, `out_valid` ← 1.
  - In mode 1 only, `ptr` ← (`g`+1) mod NCH, wrapping from NCH-1 to 0.
- Pointer hold rules:
  - `ptr` is unchanged in mode 0 and on cycles without a transfer.
  - A mode switch does not reset `ptr`.
- When FULL with `out_ready`=1 and no new transfer, `out_valid` ← 0. `out_data` and `out_ch` hold their last value.
- Simultaneous output drain and input transfer: the stage stays FULL with the new word. There is no bubble.
- Transfers are never dropped or duplicated. A held word stays stable while `out_valid` && !`out_ready`.
- Reset, including mid-transfer:
  - `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0, state EMPTY. Any in-flight word is discarded.
  - `in_ready` is forced to 0 while `rst_n` is low.

## Timing
- Latency is 1 cycle: a word accepted at edge n is visible on `out_*` after edge n.
- Throughput is 1 word/cycle with `out_ready` held high.
- Without MUX_SKID_EN, `in_ready` is combinational from `out_ready`, `mode`, `sel`, `in_valid` and `ptr`.
- Round-robin fairness: a continuously valid channel is granted within NCH transfers.
- Grant logic is a priority search over at most NCH entries. Required: single-cycle closure at NCH=32.

## Configuration
- `MUX_SKID_EN` defined:
  - Adds a one-word skid register, giving states EMPTY/FULL/SKID.
  - `accept` depends only on registered state: SKID empty, so `in_ready` has no combinational path from `out_ready`.
  - On a FULL-stall transfer, the word goes to the skid register. It moves to the output when `out_ready`=1, preserving order.
  - Latency stays 1 cycle and throughput stays 1 word/cycle.
- `MUX_SKID_EN` undefined: no skid register; behaviour is as in Operation.

## Structure
- Shared package `mux_pkg`:
  - `mode_e` enum: MODE_SEL=0, MODE_RR=1.
  - `ostate_e` enum: EMPTY, FULL, SKID.
  - NCH limit constant `MUX_NCH_MAX`=64.
- Sub-module `rr_arbiter`: parameter NCH; inputs `req`, `ptr`; outputs one-hot `gnt`, index `gnt_idx`, `gnt_any`. `mux_rr` owns `ptr` and the output stage.

## Test plan
- Reset check: assert `rst_n`=0 mid-transfer with `out_valid`=1 → `out_valid`=0, `out_ch`=0, `ptr`=0, all `in_ready`=0 immediately (asynchronous).
- Direct mode, NCH=32: `mode`=0, `sel`=5, `in_valid[5]`=1, `in_data[5]`=32'hDEADBEEF, `out_ready`=1 → next cycle `out_data`=32'hDEADBEEF, `out_ch`=5. With `sel`=31 and `in_data[31]`=32'h1 → `out_data`=1.
- Invalid select: NCH=20, `mode`=0, `sel`=25 → `in_ready`=0, `out_valid` stays 0.
- Round-robin: channels 3, 7 and 31 continuously valid, `ptr`=0 → grant order 3, 7, 31, 3, 7; `ptr` after the grant to 31 = 0 (wrap).
- Backpressure: `out_ready`=0 for 4 cycles with FULL → `out_data` stable and `in_ready`=0 (skid build: one extra word accepted, then 0). After release, words arrive in order with no loss or duplication.
- Simultaneous drain and fill: `out_ready`=1 and a new transfer in the same cycle for 10 cycles → 10 consecutive `out_valid`=1 beats with no bubble.
